out_act_wb: RTL

//  Write-back stage of the PE pipeline, directly downstream of the add stage.

---
 rtl/out_act_wb_pkg.sv | 20 ++
 rtl/out_act_wb_rf.sv | 54 +++++
 rtl/out_act_wb.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/out_act_wb_pkg.sv
// ----------------------------------------------------------------------------
// out_act_wb_pkg
//  Shared sizing constants and FSM state encoding for the PE write-back stage.
//  DATA_W : activation / partial-sum width (PE data bus width)
//  ACT_NO : output activations held per PE (register file depth)
//  ACT_AW : activation index width, $clog2(ACT_NO)
// ----------------------------------------------------------------------------
package out_act_wb_pkg;

    localparam int DATA_W = 16;
    localparam int ACT_NO = 16;
    localparam int ACT_AW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } wb_state_t;

endpackage

// File: rtl/out_act_wb_rf.sv
// ----------------------------------------------------------------------------
// out_act_wb_rf
//  Output-activation register file: flop array with one write port, one
//  registered write-first read port and one combinational drain read port.
//  Ports:
//   clk, rst                 clock, async active-high reset (clears array)
//   i_wr_en/addr/data        write port, commits at the clock edge
//   i_rd_en/addr, o_rd_data  registered read; holds while i_rd_en=0
//   i_dr_addr, o_dr_data     combinational read used by the drain path
// ----------------------------------------------------------------------------
module out_act_wb_rf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic [AW-1:0]     i_dr_addr,
    output logic [DATA_W-1:0] o_dr_data
);

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [DATA_W-1:0]            r_rd_data;
    logic                         w_bypass;

    // Write-first: a same-cycle write to the read address is forwarded.
    assign w_bypass = i_wr_en && (i_wr_addr == i_rd_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= w_bypass ? i_wr_data : r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_dr_data = r_mem[i_dr_addr];

endmodule

// File: rtl/out_act_wb.sv
// ----------------------------------------------------------------------------
// out_act_wb
//  PE pipeline write-back stage. Commits add-stage results into the output
//  activation register file, serves the accumulator read port, and runs the
//  CLEAR (zero all entries) and DRAIN (stream all entries out) sequences.
//  Ports:
//   clk, rst                               clock, async active-high reset
//   comp_en_wb, out_act_addr_wb,
//   add_result_wb                          write from the add stage
//   rd_en, rd_addr, rd_data                accumulator read, 1-cycle latency
//   clear_start, drain_start               sequence start pulses (IDLE only)
//   out_valid, out_ready, out_addr,
//   out_data                               drain stream, valid/ready
//   busy                                   CLEAR or DRAIN in progress
//   done                                   1-cycle pulse when a sequence ends
//   err_wr_busy                            sticky: write dropped while busy
// ----------------------------------------------------------------------------
module out_act_wb
    import out_act_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              comp_en_wb,
    input  logic [ACT_AW-1:0] out_act_addr_wb,
    input  logic [DATA_W-1:0] add_result_wb,
    input  logic              rd_en,
    input  logic [ACT_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clear_start,
    input  logic              drain_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACT_AW-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err_wr_busy
);

    localparam logic [ACT_AW-1:0] PTR_LAST = ACT_AW'(ACT_NO - 1);

    wb_state_t         r_state, w_state_nxt;
    logic [ACT_AW-1:0] r_ptr, w_ptr_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [ACT_AW-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_done, w_done_nxt;
    logic              r_err;
    logic              w_out_load;
    logic              w_fire;
    logic              w_err_set;
    logic              w_wr_en;
    logic [ACT_AW-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_dr_data;

    assign w_fire = r_out_valid & out_ready;

    // The single RF write port is shared between add-stage commits (IDLE)
    // and the CLEAR sweep; outside IDLE the add-stage write is dropped.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_out_valid_nxt = r_out_valid;
        w_out_load      = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_set       = 1'b0;
        w_wr_en         = 1'b0;
        w_wr_addr       = out_act_addr_wb;
        w_wr_data       = add_result_wb;
        case (r_state)
            ST_IDLE: begin
                w_wr_en = comp_en_wb;
                if (clear_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end else if (drain_start) begin
                    w_state_nxt     = ST_DRAIN;
                    w_ptr_nxt       = '0;
                    w_out_valid_nxt = 1'b1;
                    w_out_load      = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_err_set = comp_en_wb;
                w_wr_en   = 1'b1;
                w_wr_addr = r_ptr;
                w_wr_data = '0;
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + ACT_AW'(1);
                end
            end
            ST_DRAIN: begin
                w_err_set = comp_en_wb;
                if (w_fire) begin
                    if (r_ptr == PTR_LAST) begin
                        w_state_nxt     = ST_IDLE;
                        w_ptr_nxt       = '0;
                        w_out_valid_nxt = 1'b0;
                        w_done_nxt      = 1'b1;
                    end else begin
                        w_ptr_nxt  = r_ptr + ACT_AW'(1);
                        w_out_load = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_ptr_nxt       = '0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Drain outputs are registered: the entry at the next pointer is
    // pre-fetched so out_* are stable for as long as out_ready stays low.
    // The array cannot change during DRAIN since writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_addr <= '0;
            r_out_data <= '0;
        end else if (w_out_load) begin
            r_out_addr <= w_ptr_nxt;
            r_out_data <= w_dr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    out_act_wb_rf #(
        .DATA_W (DATA_W),
        .DEPTH  (ACT_NO),
        .AW     (ACT_AW)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .i_dr_addr (w_ptr_nxt),
        .o_dr_data (w_dr_data)
    );

    assign out_valid   = r_out_valid;
    assign out_addr    = r_out_addr;
    assign out_data    = r_out_data;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign err_wr_busy = r_err;

endmodule
